tap_sequencer: RTL and testbench

Hardware JTAG master that drives the TMS/TDI pins of a downstream TAP (ASIC_with_TAP) from parallel scan commands and collects TDO into a parallel word. It replaces the bench-level TMS task sequences and the TDI generator / TDO monitor pair with one synthesizable block. A host issues an IR or DR scan of 1..MAX_LEN bits with an optional pause. The block walks the TAP state machine Run_Idle → scan → Run_Idle and returns the captured bits.

---
 rtl/tap_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_tap_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tap_sequencer.sv
// tap_sequencer: JTAG master that walks a downstream TAP from Run_Idle through
// an IR or DR scan (with optional Pause) and back. It shifts out data_in
// LSB first on TDI and returns the TDO bits captured at each shift edge.
// TMS/TDI are registered, so the value set at one edge is seen by the TAP at the next edge.
module tap_sequencer #(
    parameter int MAX_LEN = 14,
    parameter int LEN_W   = 4,
    parameter int PAUSE_W = 6
) (
    input  logic               TCK,
    input  logic               reset_b,
    input  logic               start,
    input  logic               is_ir,
    input  logic [LEN_W-1:0]   scan_len,
    input  logic [MAX_LEN-1:0] data_in,
    input  logic [PAUSE_W-1:0] pause_cycles,
    input  logic               TDO,
    output logic               TMS,
    output logic               TDI,
    output logic               busy,
    output logic               done,
    output logic               cmd_err,
    output logic [MAX_LEN-1:0] data_out
);

    // state names the TAP state the TAP is in after the current edge
    typedef enum logic [3:0] {
        INIT, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT,
        EXIT1, PAUSE, EXIT2, UPDATE, ERR
    } state_t;

    state_t             state;
    logic [2:0]         init_cnt;
    logic [LEN_W-1:0]   bit_cnt;
    logic [LEN_W-1:0]   next_bit;
    logic [LEN_W-1:0]   last_bit;
    logic [LEN_W-1:0]   len_q;
    logic [PAUSE_W-1:0] pause_cnt;
    logic [PAUSE_W-1:0] pause_q;
    logic               is_ir_q;
    logic [MAX_LEN-1:0] data_q;
    logic [MAX_LEN-1:0] cap_q;
    logic               accept;
    logic               reject;

    // Lengths beyond the longest register are treated as a full-length scan
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len > LEN_W'(MAX_LEN))
            return LEN_W'(MAX_LEN);
        return len;
    endfunction

    // A command is only looked at while parked in Run_Idle with nothing pending
    assign accept   = (state == IDLE) && !busy && start && (scan_len != '0);
    assign reject   = (state == IDLE) && !busy && start && (scan_len == '0);
    assign last_bit = len_q - LEN_W'(1);
    assign next_bit = bit_cnt + LEN_W'(1);

    // Latch the command at acceptance so the host may change its inputs afterwards
    always_ff @(posedge TCK) begin
        if (accept) begin
            is_ir_q <= is_ir;
            len_q   <= clamp_len(scan_len);
            data_q  <= data_in;
            pause_q <= pause_cycles;
        end
    end

    // Capture register: cleared per command so bits past the scan length read as 0
    always_ff @(posedge TCK) begin
        if (accept)
            cap_q <= '0;
        else if (state == SHIFT)
            cap_q[bit_cnt] <= TDO;
    end

    // TAP walk: mirrors the TAP state and registers the TMS/TDI for the next edge
    always_ff @(posedge TCK) begin
        if (!reset_b) begin
            state    <= INIT;
            init_cnt <= '0;
            TMS      <= 1'b1;
            TDI      <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            cmd_err  <= 1'b0;
            data_out <= '0;
        end else begin
            done    <= 1'b0;
            cmd_err <= 1'b0;
            case (state)
                INIT: begin
                    // Five TMS=1 edges force Test-Logic-Reset, the sixth (TMS=0) lands in Run_Idle
                    init_cnt <= init_cnt + 3'd1;
                    if (init_cnt == 3'd4)
                        TMS <= 1'b0;
                    if (init_cnt == 3'd5) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (busy) begin
                        state <= SEL_DR;
                        TMS   <= is_ir_q;
                    end else if (accept) begin
                        busy <= 1'b1;
                        TMS  <= 1'b1;
                    end else if (reject) begin
                        state <= ERR;
                    end
                end
                ERR: begin
                    state   <= IDLE;
                    cmd_err <= 1'b1;
                end
                SEL_DR: begin
                    state <= is_ir_q ? SEL_IR : CAPTURE;
                    TMS   <= 1'b0;
                end
                SEL_IR: begin
                    state <= CAPTURE;
                    TMS   <= 1'b0;
                end
                CAPTURE: begin
                    state   <= SHIFT;
                    bit_cnt <= '0;
                    TDI     <= data_q[0];
                    TMS     <= (last_bit == '0);
                end
                SHIFT: begin
                    if (bit_cnt == last_bit) begin
                        state <= EXIT1;
                        TDI   <= 1'b1;
                        TMS   <= (pause_q == '0);
                    end else begin
                        bit_cnt <= next_bit;
                        TDI     <= data_q[next_bit];
                        TMS     <= (next_bit == last_bit);
                    end
                end
                EXIT1: begin
                    if (pause_q == '0) begin
                        state <= UPDATE;
                        TMS   <= 1'b0;
                    end else begin
                        // pause_cnt counts the remaining TMS=0 edges spent inside Pause
                        state     <= PAUSE;
                        pause_cnt <= pause_q - PAUSE_W'(1);
                        TMS       <= (pause_q == PAUSE_W'(1));
                    end
                end
                PAUSE: begin
                    if (pause_cnt == '0) begin
                        state <= EXIT2;
                        TMS   <= 1'b1;
                    end else begin
                        pause_cnt <= pause_cnt - PAUSE_W'(1);
                        TMS       <= (pause_cnt == PAUSE_W'(1));
                    end
                end
                EXIT2: begin
                    state <= UPDATE;
                    TMS   <= 1'b0;
                end
                UPDATE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    data_out <= cap_q;
                    TMS      <= 1'b0;
                end
                default: begin
                    state    <= INIT;
                    init_cnt <= '0;
                    TMS      <= 1'b1;
                    TDI      <= 1'b1;
                    busy     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tap_sequencer.sv
// Bench for tap_sequencer: random TDO stream, expected TMS/TDI/data_out built
// from the scan rules (path, shift, pause, update) as edge-indexed bit lists.
module tb_tap_sequencer;

    logic        TCK;
    logic        reset_b;
    logic        start;
    logic        is_ir;
    logic [3:0]  scan_len;
    logic [13:0] data_in;
    logic [5:0]  pause_cycles;
    logic        TDO;
    logic        TMS;
    logic        TDI;
    logic        busy;
    logic        done;
    logic        cmd_err;
    logic [13:0] data_out;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [13:0] dout_hold = '0;

    tap_sequencer #(.MAX_LEN(14), .LEN_W(4), .PAUSE_W(6)) dut (
        .TCK(TCK), .reset_b(reset_b), .start(start), .is_ir(is_ir),
        .scan_len(scan_len), .data_in(data_in), .pause_cycles(pause_cycles),
        .TDO(TDO), .TMS(TMS), .TDI(TDI), .busy(busy), .done(done),
        .cmd_err(cmd_err), .data_out(data_out)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Issue one command and check the whole walk against the rule-built model
    task automatic run_cmd(input logic ir, input logic [3:0] len, input logic [13:0] din,
                           input logic [5:0] pz, input bit poke, output logic [127:0] tms_seen);
        int          n_req;
        int          pre;
        int          n_exp;
        int          n_obs;
        int          busy_bad;
        int          side_bad;
        int          hold_bad;
        bit          seq[$];
        bit          tdo_hist[0:127];
        logic [127:0] tms_exp;
        logic [127:0] tdi_exp;
        logic [127:0] tms_obs;
        logic [127:0] tdi_obs;
        logic [13:0] dexp;

        n_req = (len > 4'd14) ? 14 : int'(len);
        pre   = ir ? 4 : 3;
        n_exp = pre + n_req + ((pz > 0) ? int'(pz) + 3 : 2);

        seq.delete();
        seq.push_back(1'b1);
        if (ir) seq.push_back(1'b1);
        seq.push_back(1'b0);
        seq.push_back(1'b0);
        for (int i = 0; i < n_req; i++) seq.push_back(i == n_req - 1);
        if (pz > 0) begin
            for (int j = 0; j < int'(pz); j++) seq.push_back(1'b0);
            seq.push_back(1'b1);
            seq.push_back(1'b1);
            seq.push_back(1'b0);
        end else begin
            seq.push_back(1'b1);
            seq.push_back(1'b0);
        end
        tms_exp = '0;
        tdi_exp = '0;
        foreach (seq[i]) begin
            tms_exp[i+1] = seq[i];
            tdi_exp[i+1] = 1'b1;
        end
        for (int i = 0; i < n_req; i++) tdi_exp[pre+1+i] = din[i];

        @(negedge TCK);
        is_ir = ir; scan_len = len; data_in = din; pause_cycles = pz; start = 1'b1;
        @(posedge TCK);
        #1;
        start = 1'b0;
        is_ir = 1'($urandom); scan_len = 4'($urandom); data_in = 14'($urandom);
        pause_cycles = 6'($urandom);

        tms_obs = '0; tdi_obs = '0; n_obs = 0;
        busy_bad = 0; side_bad = 0; hold_bad = 0;
        for (int k = 1; k < 128; k++) begin
            @(negedge TCK);
            tms_obs[k] = TMS;
            tdi_obs[k] = TDI;
            if (busy !== 1'b1) busy_bad++;
            if (done !== 1'b0 || cmd_err !== 1'b0) side_bad++;
            if (data_out !== dout_hold) hold_bad++;
            TDO = 1'($urandom_range(0, 1));
            tdo_hist[k] = TDO;
            if (poke && k == 3) start = 1'b1;
            if (poke && k == 4) start = 1'b0;
            @(posedge TCK);
            #1;
            if (done === 1'b1) begin
                n_obs = k;
                break;
            end
        end
        start = 1'b0;

        dexp = '0;
        for (int i = 0; i < n_req; i++) dexp[i] = tdo_hist[pre+1+i];

        n_assert++;
        if (n_obs != n_exp) begin
            n_fail++;
            $display("FAIL edge_count ir=%0d len=%0d p=%0d: got %0d want %0d", ir, len, pz, n_obs, n_exp);
        end
        n_assert++;
        if (tms_obs !== tms_exp) begin
            n_fail++;
            $display("FAIL tms_seq ir=%0d len=%0d p=%0d: got %h want %h", ir, len, pz, tms_obs, tms_exp);
        end
        n_assert++;
        if (tdi_obs !== tdi_exp) begin
            n_fail++;
            $display("FAIL tdi_seq ir=%0d len=%0d: got %h want %h", ir, len, tdi_obs, tdi_exp);
        end
        n_assert++;
        if (data_out !== dexp) begin
            n_fail++;
            $display("FAIL data_out ir=%0d len=%0d: got %h want %h", ir, len, data_out, dexp);
        end
        n_assert++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_done: got %b want 0", busy);
        end
        n_assert++;
        if (busy_bad != 0 || side_bad != 0 || hold_bad != 0) begin
            n_fail++;
            $display("FAIL during_scan: busy_low=%0d stray_pulse=%0d dout_change=%0d want 0/0/0",
                     busy_bad, side_bad, hold_bad);
        end
        dout_hold = dexp;
        tms_seen  = tms_obs;
    endtask

    // Parked cycles: done pulse ended, TAP held in Run_Idle, data_out held
    task automatic idle(input int cycles);
        int bad;
        bad = 0;
        repeat (cycles) begin
            @(posedge TCK);
            #1;
            if (done !== 1'b0 || busy !== 1'b0 || TMS !== 1'b0 || TDI !== 1'b1 ||
                cmd_err !== 1'b0 || data_out !== dout_hold) bad++;
        end
        n_assert++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL idle_state: %0d bad cycles want 0", bad);
        end
    endtask

    // Count edges from release to busy falling, recording the TMS walk
    task automatic walk_after_release(input string tag);
        logic [6:0] tms_w;
        logic [6:0] want;
        int         fall;
        int         done_seen;
        tms_w = '0; fall = 0; done_seen = 0;
        want = 7'b0111110;
        @(negedge TCK);
        reset_b = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            if (k <= 6) tms_w[k] = TMS;
            @(posedge TCK);
            #1;
            if (done === 1'b1) done_seen++;
            if (fall == 0 && busy === 1'b0) fall = k;
            @(negedge TCK);
            if (fall != 0) break;
        end
        n_assert++;
        if (tms_w !== want) begin
            n_fail++;
            $display("FAIL %s_tms_walk: got %b want %b", tag, tms_w[6:1], want[6:1]);
        end
        n_assert++;
        if (fall != 6 || done_seen != 0) begin
            n_fail++;
            $display("FAIL %s_busy_fall: got edge %0d done=%0d want edge 6 done=0", tag, fall, done_seen);
        end
        n_assert++;
        if (data_out !== 14'h0) begin
            n_fail++;
            $display("FAIL %s_dout: got %h want 0", tag, data_out);
        end
        dout_hold = '0;
    endtask

    task automatic test_reset();
        logic [18:0] got;
        reset_b = 1'b0; start = 1'b0; is_ir = 1'b0; scan_len = '0;
        data_in = '0; pause_cycles = '0; TDO = 1'b0;
        repeat (3) @(posedge TCK);
        @(negedge TCK);
        got = {TMS, TDI, busy, done, cmd_err, data_out};
        n_assert++;
        if (got !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 14'h0}) begin
            n_fail++;
            $display("FAIL reset_values: got %h want %h", got, {5'b11100, 14'h0});
        end
        walk_after_release("reset");
    endtask

    task automatic test_bypass();
        logic [127:0] t;
        idle(2);
        run_cmd(1'b0, 4'd14, 14'h2AAA, 6'd0, 1'b0, t);
    endtask

    task automatic test_ir_pause();
        logic [127:0] t;
        logic [11:0]  want;
        want = 12'b0110_0100_0011;
        run_cmd(1'b1, 4'd3, 14'b011, 6'd2, 1'b0, t);
        n_assert++;
        if (t[12:1] !== want) begin
            n_fail++;
            $display("FAIL ir_tms_fixed: got %b want %b (edge12..edge1)", t[12:1], want);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] t;
        run_cmd(1'b0, 4'd14, 14'b0100_1_1010_1010_0, 6'd0, 1'b0, t);
        run_cmd(1'b0, 4'd14, 14'h3FFF, 6'd0, 1'b0, t);
        idle(2);
    endtask

    task automatic test_len_zero();
        int tms_bad;
        logic [2:0] err_seq;
        logic [2:0] busy_seq;
        tms_bad = 0;
        @(negedge TCK);
        start = 1'b1; scan_len = 4'd0; is_ir = 1'b1; data_in = 14'h1234; pause_cycles = 6'd3;
        for (int k = 0; k < 3; k++) begin
            @(posedge TCK);
            #1;
            start = 1'b0;
            err_seq[k]  = cmd_err;
            busy_seq[k] = busy;
            @(negedge TCK);
            if (TMS !== 1'b0) tms_bad++;
        end
        n_assert++;
        if (err_seq !== 3'b010) begin
            n_fail++;
            $display("FAIL len0_cmd_err: got %b want 010 (E2,E1,E0)", err_seq);
        end
        n_assert++;
        if (busy_seq !== 3'b000 || tms_bad != 0 || data_out !== dout_hold) begin
            n_fail++;
            $display("FAIL len0_quiet: busy=%b tms_bad=%0d dout=%h want 000/0/%h",
                     busy_seq, tms_bad, data_out, dout_hold);
        end
        idle(2);
    endtask

    task automatic test_busy_start_and_clamp();
        logic [127:0] t;
        run_cmd(1'b0, 4'd6, 14'h0015, 6'd1, 1'b1, t);
        idle(4);
        run_cmd(1'b1, 4'd15, 14'h1C3A, 6'd0, 1'b0, t);
        idle(1);
    endtask

    task automatic test_random();
        logic [127:0] t;
        logic [5:0]   pz;
        for (int r = 0; r < 12; r++) begin
            pz = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(1, 9));
            run_cmd(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), 14'($urandom),
                    pz, 1'($urandom_range(0, 1)), t);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end
        run_cmd(1'b1, 4'd14, 14'($urandom), 6'd63, 1'b0, t);
        run_cmd(1'b0, 4'd1, 14'($urandom), 6'd0, 1'b0, t);
        idle(1);
    endtask

    task automatic test_reset_mid_scan();
        logic [18:0] got;
        @(negedge TCK);
        is_ir = 1'b0; scan_len = 4'd14; data_in = 14'($urandom); pause_cycles = 6'd0; start = 1'b1;
        @(posedge TCK);
        #1;
        start = 1'b0;
        repeat (10) @(posedge TCK);
        @(negedge TCK);
        reset_b = 1'b0;
        @(posedge TCK);
        #1;
        got = {TMS, TDI, busy, done, cmd_err, data_out};
        n_assert++;
        if (got !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 14'h0}) begin
            n_fail++;
            $display("FAIL midscan_reset: got %h want %h", got, {5'b11100, 14'h0});
        end
        walk_after_release("midscan");
        idle(2);
        test_bypass();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_ir_pause();
        test_back_to_back();
        test_len_zero();
        test_busy_start_and_clamp();
        test_random();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
